lc3b_mem_if: RTL
================

Name: lc3b_mem_if

Overview:
Memory-interface stage for the LC-3b datapath: holds MAR and MDR, runs the multi-cycle memory handshake and returns the ready signal R to the microsequencer.
- Consumes BUS values produced by the register-file/ALU/address path.
- Produces MDR_out, which is gated onto BUS (GateMDR) and written back into the register file.
- Hides external memory latency behind a fixed minimum-latency counter, modelling LC-3b multi-cycle memory.

Parameters:
MIN_LAT, 5, minimum cycles from access start to R assertion (1..15)
TIMEOUT, 64, cycles to wait for mem_ack before a forced bus error (used only with TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
BUS  in  16  processor bus value
LD_MAR  in  1  load MAR from BUS
LD_MDR  in  1  load MDR (source chosen by MIO_EN)
MIO_EN  in  1  memory access requested / MDR source select
R_W  in  1  0 = read, 1 = write
DATA_SIZE  in  1  0 = byte, 1 = word
MAR_out  out  16  current MAR
MDR_out  out  16  MDR formatted for GateMDR
R  out  1  access complete, one-cycle pulse
unaligned  out  1  sticky word-access-to-odd-address flag
bus_err  out  1  sticky timeout flag (0 when TIMEOUT_EN is undefined)
mem_req  out  1  external request, held until ack
mem_we  out  1  external write enable
mem_addr  out  15  word address = MAR[15:1]
mem_be  out  2  byte enables
mem_wdata  out  16  write data = MDR
mem_rdata  in  16  read data, valid with mem_ack
mem_ack  in  1  external acknowledge

Behaviour:
- Reset: MAR=0, MDR=0, R=0, mem_req=0, mem_we=0, unaligned=0, bus_err=0, counters=0, FSM=IDLE.
- Reset mid-access abandons the access. A mem_ack arriving in IDLE is ignored.
- MAR: on LD_MAR, MAR<=BUS. LD_MAR also clears unaligned.
- MDR load, MIO_EN=0: on LD_MDR, word: MDR<=BUS; byte: MDR<={BUS[7:0],BUS[7:0]}.
- MDR load, MIO_EN=1: LD_MDR with R=1 on a read loads the captured read data. LD_MDR while R=0 is ignored.
- MDR_out, word: MDR.
- MDR_out, byte: sign-extended MDR[15:8] if MAR[0]=1, else sign-extended MDR[7:0]. Combinational.
- mem_be: word 2'b11; byte MAR[0]?2'b10:2'b01. mem_we=R_W. mem_addr, mem_be and mem_we are registered at access start and held stable while mem_req=1.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - MIO_EN=1 and (DATA_SIZE=0 or MAR[0]=0): latch address/control, mem_req<=1, lat_cnt<=1, go to REQ.
  - MIO_EN=1, DATA_SIZE=1, MAR[0]=1: no request; unaligned<=1; go to DONE.
- REQ:
  - mem_req held; lat_cnt increments (saturating at MIN_LAT).
  - On mem_ack: mem_req<=0; capture mem_rdata into rd_buf.
  - Then if lat_cnt>=MIN_LAT go to DONE, else go to WAIT.
- WAIT: count until lat_cnt>=MIN_LAT, then go to DONE.
- DONE: R=1 for exactly one cycle, then go to IDLE. A new access can start on the next cycle if MIO_EN is still high.
- Latency: R asserts no earlier than MIN_LAT cycles after the start cycle. With a single-cycle ack, R is high exactly MIN_LAT cycles after the start cycle.
- Unaligned access: R is high on the cycle after start. MDR is not updated from memory (rd_buf is unchanged).
- MIO_EN dropping mid-access: the access completes anyway. R is still pulsed.
- LD_MAR during an access updates MAR only; the latched mem_addr is unaffected.

Optional Feature:
TIMEOUT_EN
- Defined: a timeout counter runs in REQ. If TIMEOUT cycles pass without mem_ack:
  - mem_req<=0, bus_err<=1 (sticky until rst);
  - rd_buf<=16'h0000;
  - go to DONE and pulse R.
- Undefined: REQ waits indefinitely and bus_err is tied to 0.

Test Plan:
1. Word read: MAR=0x3000, memory returns 0x1234 with ack 1 cycle after req, MIN_LAT=5 -> mem_addr=0x1800, be=11; R high exactly 5 cycles after start; LD_MDR in that cycle -> MDR_out=0x1234.
2. Byte read: MAR=0x3001, memory word 0x80FF -> be=10; MDR_out=0xFF80. Same word with MAR=0x3000 -> MDR_out=0xFFFF.
3. Byte write: BUS=0x00A5 with LD_MDR, MIO_EN=0, DATA_SIZE=0 -> MDR=0xA5A5. Write to MAR=0x4001 -> mem_we=1, be=10, wdata=0xA5A5; R pulses once.
4. Unaligned word read: MAR=0x3003 -> mem_req never asserts; unaligned=1; R on the next cycle. A following LD_MAR clears unaligned.
5. Slow memory: ack 12 cycles after req -> R on the cycle after ack (not earlier); mem_addr stable throughout. Assert rst at cycle 6 of a second access -> mem_req=0 and FSM=IDLE next cycle; a late ack produces no R.
6. TIMEOUT_EN, TIMEOUT=64, no ack -> mem_req drops after 64 cycles; bus_err=1; R pulses; MDR load gives 0x0000.

Source files
------------

// File: rtl/lc3b_mem_if.sv
// Memory-interface stage of the LC-3b datapath. It holds MAR and MDR, runs the request/ack
// handshake with external memory and pulses R to the microsequencer when an access completes.
// Latency: R is high no earlier than MIN_LAT cycles after the start cycle, and one cycle after mem_ack.
// Backpressure: mem_req is held until mem_ack. The stage does not stall BUS. The sequencer waits on R.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   BUS                   processor bus value (MAR / MDR load source)
//   LD_MAR, LD_MDR        register load strobes
//   MIO_EN, R_W           access request / MDR source select; 0 = read, 1 = write
//   DATA_SIZE             0 = byte, 1 = word
//   MAR_out, MDR_out      current MAR; MDR formatted for GateMDR
//   R                     one-cycle access-complete pulse
//   unaligned, bus_err    sticky error flags
//   mem_*                 external memory request/ack interface (word addressed, byte enables)
//
// Optional feature macro: TIMEOUT_EN. When defined, REQ gives up after TIMEOUT cycles
// without mem_ack and raises bus_err. When undefined, REQ waits indefinitely and bus_err is 0.
module lc3b_mem_if #(
    parameter int MIN_LAT = 5,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] BUS,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic        DATA_SIZE,
    output logic [15:0] MAR_out,
    output logic [15:0] MDR_out,
    output logic        R,
    output logic        unaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [3:0] MIN_LAT_L = 4'(MIN_LAT);

    logic [1:0]  state;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] rd_buf;
    logic [3:0]  lat_cnt;
    logic [3:0]  lat_nxt;
    logic        lat_met;
    logic        tmo_hit;

    // lat_cnt holds the number of cycles since the start cycle. The decision to leave REQ/WAIT
    // uses the incremented count, so DONE lands exactly MIN_LAT cycles after the start cycle.
    always_comb begin
        lat_nxt = (lat_cnt >= MIN_LAT_L) ? MIN_LAT_L : lat_cnt + 4'd1;
        lat_met = (lat_nxt >= MIN_LAT_L);
    end

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          bus_err_q;

    // tmo_cnt counts REQ cycles already spent without ack. The TIMEOUT-th such cycle gives up.
    assign tmo_hit = (state == ST_REQ) && !mem_ack && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= '0;
            bus_err_q <= 1'b0;
        end else if (state == ST_REQ && !mem_ack) begin
            if (tmo_hit) begin
                bus_err_q <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign bus_err = bus_err_q;
`else
    // The timeout logic is compiled out. TIMEOUT is still referenced so that both builds share one parameter list.
    localparam logic TMO_EN = 1'b0 && (TIMEOUT > 0);

    assign tmo_hit = TMO_EN;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mar       <= '0;
            mdr       <= '0;
            rd_buf    <= '0;
            lat_cnt   <= '0;
            unaligned <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
        end else begin
            if (LD_MAR) begin
                mar       <= BUS;
                unaligned <= 1'b0;
            end

            // When MIO_EN=1, MDR only accepts memory data in the completion cycle of a read.
            // mem_we still holds the direction of the access that is finishing.
            if (LD_MDR) begin
                if (!MIO_EN) begin
                    mdr <= DATA_SIZE ? BUS : {BUS[7:0], BUS[7:0]};
                end else if (state == ST_DONE && !mem_we) begin
                    mdr <= rd_buf;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (MIO_EN) begin
                        mem_addr <= mar[15:1];
                        mem_be   <= DATA_SIZE ? 2'b11 : (mar[0] ? 2'b10 : 2'b01);
                        mem_we   <= R_W;
                        if (DATA_SIZE && mar[0]) begin
                            // A word access to an odd address never reaches memory.
                            unaligned <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            mem_req <= 1'b1;
                            lat_cnt <= 4'd1;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    lat_cnt <= lat_nxt;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rd_buf  <= mem_rdata;
                        state   <= lat_met ? ST_DONE : ST_WAIT;
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        rd_buf  <= 16'h0000;
                        state   <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_nxt;
                    if (lat_met) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign R         = (state == ST_DONE);
    assign MAR_out   = mar;
    assign mem_wdata = mdr;

    // GateMDR view: a byte access returns the selected byte lane, sign-extended.
    always_comb begin
        if (DATA_SIZE) begin
            MDR_out = mdr;
        end else if (mar[0]) begin
            MDR_out = {{8{mdr[15]}}, mdr[15:8]};
        end else begin
            MDR_out = {{8{mdr[7]}}, mdr[7:0]};
        end
    end

endmodule
